mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port `memory` block between the instruction-fetch requester and the load/store requester of the core. Each requester gets a request/grant handshake and a tagged read response. Memory-side signals are driven in the grant cycle. Read data is routed back to its owner one cycle later, matching the memory's registered read. Back-to-back grants are allowed every cycle, so one access can be in its response cycle while the next one is issued.

---
 rtl/mem_arb_pkg.sv | 12 +
 rtl/rr_arb2.sv | 45 ++++
 rtl/mem_arbiter.sv | 90 +++++++++
 tb/tb_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter.
// Owner encoding and the "no write" mask constant.
package mem_arb_pkg;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam logic [3:0] MEM_WMASK_NONE = 4'b0000;

endpackage

// File: rtl/rr_arb2.sv
// Two-input arbiter: round-robin or fixed data priority.
// One-hot grant; bit 0 = fetch, bit 1 = data.
module rr_arb2
    import mem_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    owner_e last_owner;

    // Pick a winner this cycle; nothing is granted during reset.
    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            if (req == 2'b11) begin
                if (FIXED_PRIO) begin
                    gnt = 2'b10;
                end else if (last_owner == OWN_D) begin
                    gnt = 2'b01;
                end else begin
                    gnt = 2'b10;
                end
            end else begin
                gnt = req;
            end
        end
    end

    // Remember the most recent winner for round-robin fairness.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= OWN_D;
        end else if (gnt[0]) begin
            last_owner <= OWN_IF;
        end else if (gnt[1]) begin
            last_owner <= OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and load/store.
// Drives memory in the grant cycle, routes read data one cycle later.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic [31:0] d_addr_i,
    input  logic [3:0]  d_wmask_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_rstrb_o,
    output logic [3:0]  mem_wmask_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    logic [1:0] gnt;
    logic       d_write;
    logic       rd_grant;
    owner_e     rd_owner;
    logic       rsp_pending;
    owner_e     rsp_owner;

    rr_arb2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .clk(clk),
        .rst(rst),
        .req({d_req_i, if_req_i}),
        .gnt(gnt)
    );

    assign if_gnt_o = gnt[0];
    assign d_gnt_o  = gnt[1];
    assign d_write  = (d_wmask_i != MEM_WMASK_NONE);
    assign rd_grant = gnt[0] | (gnt[1] & ~d_write);
    assign rd_owner = gnt[1] ? OWN_D : OWN_IF;

    // Steer the winner's access onto the memory port.
    always_comb begin
        mem_addr_o  = '0;
        mem_rstrb_o = 1'b0;
        mem_wmask_o = MEM_WMASK_NONE;
        mem_wdata_o = '0;
        if (gnt[0]) begin
            mem_addr_o  = if_addr_i;
            mem_rstrb_o = 1'b1;
        end else if (gnt[1]) begin
            mem_addr_o = d_addr_i;
            if (d_write) begin
                mem_wmask_o = d_wmask_i;
                mem_wdata_o = d_wdata_i;
            end else begin
                mem_rstrb_o = 1'b1;
            end
        end
    end

    // Track who owns the read data coming back next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_pending <= 1'b0;
            rsp_owner   <= OWN_IF;
        end else begin
            rsp_pending <= rd_grant;
            if (rd_grant) begin
                rsp_owner <= rd_owner;
            end
        end
    end

    // A response in flight when reset arrives is dropped.
    assign if_rvalid_o = rsp_pending & ~rst & (rsp_owner == OWN_IF);
    assign d_rvalid_o  = rsp_pending & ~rst & (rsp_owner == OWN_D);
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a scoreboard of read responses.
// Two instances: round-robin and fixed data priority.
module tb_mem_arbiter;

    typedef struct {
        bit          own;
        logic [31:0] data;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic [3:0]  d_wmask;
    logic [31:0] d_wdata;
    logic        fp_mode;
    logic        preload;

    logic        r_if_gnt, r_if_rvalid, r_d_gnt, r_d_rvalid, r_rstrb;
    logic [31:0] r_if_rdata, r_d_rdata, r_addr, r_wdata, r_rdata;
    logic [3:0]  r_wmask;
    logic        f_if_gnt, f_if_rvalid, f_d_gnt, f_d_rvalid, f_rstrb;
    logic [31:0] f_if_rdata, f_d_rdata, f_addr, f_wdata, f_rdata;
    logic [3:0]  f_wmask;

    logic        s_if_gnt, s_if_rvalid, s_d_gnt, s_d_rvalid, s_rstrb;
    logic [31:0] s_if_rdata, s_d_rdata, s_addr, s_wdata;
    logic [3:0]  s_wmask;

    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];
    logic [31:0] ref_mem [64];
    rsp_t        sbq [$];
    int          nvec;
    int          nmis;

    mem_arbiter #(.FIXED_PRIO(1'b0)) dut_rr (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr),
        .if_gnt_o(r_if_gnt), .if_rvalid_o(r_if_rvalid),
        .if_rdata_o(r_if_rdata),
        .d_req_i(d_req), .d_addr_i(d_addr),
        .d_wmask_i(d_wmask), .d_wdata_i(d_wdata),
        .d_gnt_o(r_d_gnt), .d_rvalid_o(r_d_rvalid),
        .d_rdata_o(r_d_rdata),
        .mem_addr_o(r_addr), .mem_rstrb_o(r_rstrb),
        .mem_wmask_o(r_wmask), .mem_wdata_o(r_wdata),
        .mem_rdata_i(r_rdata)
    );

    mem_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr),
        .if_gnt_o(f_if_gnt), .if_rvalid_o(f_if_rvalid),
        .if_rdata_o(f_if_rdata),
        .d_req_i(d_req), .d_addr_i(d_addr),
        .d_wmask_i(d_wmask), .d_wdata_i(d_wdata),
        .d_gnt_o(f_d_gnt), .d_rvalid_o(f_d_rvalid),
        .d_rdata_o(f_d_rdata),
        .mem_addr_o(f_addr), .mem_rstrb_o(f_rstrb),
        .mem_wmask_o(f_wmask), .mem_wdata_o(f_wdata),
        .mem_rdata_i(f_rdata)
    );

    assign s_if_gnt    = fp_mode ? f_if_gnt    : r_if_gnt;
    assign s_d_gnt     = fp_mode ? f_d_gnt     : r_d_gnt;
    assign s_if_rvalid = fp_mode ? f_if_rvalid : r_if_rvalid;
    assign s_d_rvalid  = fp_mode ? f_d_rvalid  : r_d_rvalid;
    assign s_if_rdata  = fp_mode ? f_if_rdata  : r_if_rdata;
    assign s_d_rdata   = fp_mode ? f_d_rdata   : r_d_rdata;
    assign s_addr      = fp_mode ? f_addr      : r_addr;
    assign s_rstrb     = fp_mode ? f_rstrb     : r_rstrb;
    assign s_wmask     = fp_mode ? f_wmask     : r_wmask;
    assign s_wdata     = fp_mode ? f_wdata     : r_wdata;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEADBEEF;
        if (i == 8) return 32'hAAAAAAAA;
        return 32'h1000_0000 + i;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model behind the round-robin instance (registered read).
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem_a[i] <= init_word(i);
        end else begin
            if (r_rstrb) r_rdata <= mem_a[r_addr[7:2]];
            for (int b = 0; b < 4; b++)
                if (r_wmask[b])
                    mem_a[r_addr[7:2]][8*b +: 8] <= r_wdata[8*b +: 8];
        end
    end

    // Memory model behind the fixed-priority instance.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem_b[i] <= init_word(i);
        end else begin
            if (f_rstrb) f_rdata <= mem_b[f_addr[7:2]];
            for (int b = 0; b < 4; b++)
                if (f_wmask[b])
                    mem_b[f_addr[7:2]][8*b +: 8] <= f_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: inputs are already driven; check mid-cycle, then advance.
    task automatic step(input logic eig, input logic edg);
        rsp_t        e;
        logic [31:0] ea;
        logic [31:0] ewd;
        logic [3:0]  ewm;
        logic        ers;
        #4;
        if (rst) sbq.delete();
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("if_rvalid", {31'b0, s_if_rvalid}, {31'b0, !e.own});
            chk("d_rvalid", {31'b0, s_d_rvalid}, {31'b0, e.own});
            chk("if_rdata", s_if_rdata, e.own ? 32'h0 : e.data);
            chk("d_rdata", s_d_rdata, e.own ? e.data : 32'h0);
        end else begin
            chk("if_rvalid_idle", {31'b0, s_if_rvalid}, 32'h0);
            chk("d_rvalid_idle", {31'b0, s_d_rvalid}, 32'h0);
            chk("if_rdata_idle", s_if_rdata, 32'h0);
            chk("d_rdata_idle", s_d_rdata, 32'h0);
        end
        chk("if_gnt", {31'b0, s_if_gnt}, {31'b0, eig});
        chk("d_gnt", {31'b0, s_d_gnt}, {31'b0, edg});
        ea  = '0;
        ewd = '0;
        ewm = '0;
        ers = 1'b0;
        if (eig) begin
            ea  = if_addr;
            ers = 1'b1;
            sbq.push_back('{1'b0, ref_mem[if_addr[7:2]]});
        end else if (edg) begin
            ea = d_addr;
            if (d_wmask != 4'b0000) begin
                ewm = d_wmask;
                ewd = d_wdata;
                for (int b = 0; b < 4; b++)
                    if (d_wmask[b])
                        ref_mem[d_addr[7:2]][8*b +: 8] = d_wdata[8*b +: 8];
            end else begin
                ers = 1'b1;
                sbq.push_back('{1'b1, ref_mem[d_addr[7:2]]});
            end
        end
        chk("mem_addr", s_addr, ea);
        chk("mem_rstrb", {31'b0, s_rstrb}, {31'b0, ers});
        chk("mem_wmask", {28'b0, s_wmask}, {28'b0, ewm});
        if (!ers) chk("mem_wdata", s_wdata, ewd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        nvec    = 0;
        nmis    = 0;
        rst     = 1'b1;
        preload = 1'b1;
        fp_mode = 1'b0;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_addr  = '0;
        d_wmask = '0;
        d_wdata = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        @(posedge clk);
        #1;
        preload = 1'b0;

        // reset state
        step(1'b0, 1'b0);
        rst = 1'b0;

        // fetch only
        if_req = 1'b1; if_addr = 32'h10;
        step(1'b1, 1'b0);
        if_req = 1'b0;
        step(1'b0, 1'b0);

        // data partial write, then read back
        d_req = 1'b1; d_addr = 32'h20;
        d_wmask = 4'b0011; d_wdata = 32'h12345678;
        step(1'b0, 1'b1);
        d_wmask = 4'b0000; d_wdata = '0;
        step(1'b0, 1'b1);
        d_req = 1'b0;
        step(1'b0, 1'b0);

        // reset, then round-robin contention
        rst = 1'b1;
        step(1'b0, 1'b0);
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h0;
        d_req = 1'b1; d_addr = 32'h4;
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        if_req = 1'b0; d_req = 1'b0;
        step(1'b0, 1'b0);

        // fixed data priority
        fp_mode = 1'b1;
        if_req = 1'b1; d_req = 1'b1;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        d_req = 1'b0;
        step(1'b1, 1'b0);
        if_req = 1'b0;
        step(1'b0, 1'b0);
        fp_mode = 1'b0;

        // back-to-back reads from different owners
        if_req = 1'b1; if_addr = 32'h0;
        step(1'b1, 1'b0);
        if_req = 1'b0; d_req = 1'b1; d_addr = 32'h4;
        step(1'b0, 1'b1);
        d_req = 1'b0;
        step(1'b0, 1'b0);

        // write granted in the previous read's response cycle
        if_req = 1'b1; if_addr = 32'h10;
        step(1'b1, 1'b0);
        if_req = 1'b0; d_req = 1'b1; d_addr = 32'h30;
        d_wmask = 4'b1111; d_wdata = 32'hCAFEF00D;
        step(1'b0, 1'b1);
        d_req = 1'b0; d_wmask = 4'b0000; d_wdata = '0;
        d_addr = 32'h30;
        d_req = 1'b1;
        step(1'b0, 1'b1);
        d_req = 1'b0;
        step(1'b0, 1'b0);

        // reset in the response cycle drops the response
        if_req = 1'b1; if_addr = 32'h10;
        step(1'b1, 1'b0);
        if_req = 1'b0; rst = 1'b1;
        step(1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 1'b0);
        if_req = 1'b1; if_addr = 32'h0;
        d_req = 1'b1; d_addr = 32'h4;
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        if_req = 1'b0; d_req = 1'b0;
        step(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
